// File: rtl/adder_pkg.sv
// Shared constants for the adder library: default lane count and the
// output-mode encodings used to pick combinational or registered results.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Values accepted by the REGISTERED parameter of half_adder.
    localparam int COMB = 0;
    localparam int REG  = 1;

endpackage : adder_pkg

// File: rtl/half_adder_cell.sv
// Single-lane half adder: sum is the XOR of the operands and carry is their AND.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// Bit-parallel half adder with independent lanes. REGISTERED chooses between
// combinational outputs and a single-cycle output register stage with a valid flag.
module half_adder
    import adder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int REGISTERED = COMB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] C,
    output logic             V
);

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] carry_w;

    generate
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "half_adder: WIDTH must be at least 1");
        end
        if ((REGISTERED != COMB) && (REGISTERED != REG)) begin : g_bad_mode
            $fatal(1, "half_adder: REGISTERED must be 0 or 1");
        end
    endgenerate

    // One cell per lane; lanes never exchange carries, so an unknown on one
    // lane cannot leak into its neighbours.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_lane
            half_adder_cell u_cell (
                .a (A[i]),
                .b (B[i]),
                .s (sum_w[i]),
                .c (carry_w[i])
            );
        end
    endgenerate

    generate
        if (REGISTERED == REG) begin : g_reg
            logic [WIDTH-1:0] s_d, s_q;
            logic [WIDTH-1:0] c_d, c_q;
            logic             v_d, v_q;

            // Idle cycles keep the last result but drop the valid flag.
            always_comb begin
                s_d = s_q;
                c_d = c_q;
                v_d = 1'b0;
                if (EN) begin
                    s_d = sum_w;
                    c_d = carry_w;
                    v_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s_q <= '0;
                    c_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    s_q <= s_d;
                    c_q <= c_d;
                    v_q <= v_d;
                end
            end

            assign S = s_q;
            assign C = c_q;
            assign V = v_q;
        end else begin : g_comb
            // clk and rst have no role in the unclocked datapath.
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst;

            assign S = sum_w;
            assign C = carry_w;
            assign V = EN;
        end
    endgenerate

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a 1-lane combinational instance, an 8-lane
// registered instance for directed cases and a 16-lane registered random pipeline.
module tb_half_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       c_rst, c_en, c_v;
    logic [0:0] c_a, c_b, c_s, c_c;

    logic       r8_rst, r8_en, r8_v;
    logic [7:0] r8_a, r8_b, r8_s, r8_c;

    logic        r16_rst, r16_en, r16_v;
    logic [15:0] r16_a, r16_b, r16_s, r16_c;

    half_adder #(.WIDTH(1), .REGISTERED(0)) u_comb (
        .clk (clk), .rst (c_rst), .EN (c_en),
        .A (c_a), .B (c_b), .S (c_s), .C (c_c), .V (c_v)
    );

    half_adder #(.WIDTH(8), .REGISTERED(1)) u_reg8 (
        .clk (clk), .rst (r8_rst), .EN (r8_en),
        .A (r8_a), .B (r8_b), .S (r8_s), .C (r8_c), .V (r8_v)
    );

    half_adder #(.WIDTH(16), .REGISTERED(1)) u_reg16 (
        .clk (clk), .rst (r16_rst), .EN (r16_en),
        .A (r16_a), .B (r16_b), .S (r16_s), .C (r16_c), .V (r16_v)
    );

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input logic [15:0] s, input logic [15:0] c, input logic v);
        exp_t e;
        e.s = s;
        e.c = c;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic popExp(input string tag, output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        e  = '0;
        if (ok) begin
            e = sb.pop_front();
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s observed=empty-scoreboard expected=entry", tag);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus8(input logic rst, input logic en, input logic [7:0] a, input logic [7:0] b);
        r8_rst = rst;
        r8_en  = en;
        r8_a   = a;
        r8_b   = b;
    endtask

    task automatic compare8(input string tag);
        exp_t e;
        bit   ok;
        popExp(tag, e, ok);
        if (ok) begin
            checkOutput({tag, ".S"}, {8'h00, r8_s}, e.s);
            checkOutput({tag, ".C"}, {8'h00, r8_c}, e.c);
            checkOutput({tag, ".V"}, {15'h0, r8_v}, {15'h0, e.v});
        end
    endtask

    task automatic compareComb(input string tag);
        exp_t e;
        bit   ok;
        popExp(tag, e, ok);
        if (ok) begin
            checkOutput({tag, ".S"}, {15'h0, c_s}, e.s);
            checkOutput({tag, ".C"}, {15'h0, c_c}, e.c);
            checkOutput({tag, ".V"}, {15'h0, c_v}, {15'h0, e.v});
            checkOutput({tag, ".excl"}, {15'h0, c_s & c_c}, 16'h0);
        end
    endtask

    task automatic compare16(input string tag);
        exp_t e;
        bit   ok;
        popExp(tag, e, ok);
        if (ok) begin
            checkOutput({tag, ".S"}, r16_s, e.s);
            checkOutput({tag, ".C"}, r16_c, e.c);
            checkOutput({tag, ".V"}, {15'h0, r16_v}, {15'h0, e.v});
            checkOutput({tag, ".excl"}, r16_s & r16_c, 16'h0);
        end
    endtask

    initial begin
        logic [1:0]  pat;
        logic [15:0] ra, rb, held_s, held_c;
        logic        ren;

        c_rst = 1'b0; c_en = 1'b0; c_a = '0; c_b = '0;
        applyStimulus8(1'b1, 1'b0, 8'h00, 8'h00);
        r16_rst = 1'b1; r16_en = 1'b0; r16_a = '0; r16_b = '0;

        // Reset state of both registered instances.
        tick;
        pushExp(16'h0, 16'h0, 1'b0);
        compare8("r8.reset");
        pushExp(16'h0, 16'h0, 1'b0);
        compare16("r16.reset");
        r8_rst  = 1'b0;
        r16_rst = 1'b0;

        // Combinational truth table, then random pairs with random EN/rst.
        for (int i = 0; i < 14; i++) begin
            if (i < 4) begin
                pat  = i[1:0];
                c_en = 1'b1;
            end else begin
                pat   = 2'($urandom_range(0, 3));
                c_en  = 1'($urandom_range(0, 1));
                c_rst = 1'($urandom_range(0, 1));
            end
            c_a = pat[1];
            c_b = pat[0];
            pushExp({15'h0, pat[1] ^ pat[0]}, {15'h0, pat[1] & pat[0]}, c_en);
            #1;
            compareComb($sformatf("comb.ab%b", pat));
            #4;
        end
        c_rst = 1'b0;

        // Two back-to-back captures, one per cycle.
        applyStimulus8(1'b0, 1'b1, 8'hF0, 8'h3C);
        pushExp(16'h00CC, 16'h0030, 1'b1);
        tick;
        compare8("r8.f0_3c");
        applyStimulus8(1'b0, 1'b1, 8'hFF, 8'hFF);
        pushExp(16'h0000, 16'h00FF, 1'b1);
        tick;
        compare8("r8.ff_ff");
        pushExp(16'h0000, 16'h00FF, 1'b1);
        tick;
        compare8("r8.stable");

        // Hold: EN low keeps the last result while operands change.
        applyStimulus8(1'b0, 1'b1, 8'h01, 8'h00);
        pushExp(16'h0001, 16'h0000, 1'b1);
        tick;
        compare8("r8.hold_load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus8(1'b0, 1'b0, 8'hFF, 8'hFF);
            pushExp(16'h0001, 16'h0000, 1'b0);
            tick;
            compare8($sformatf("r8.hold%0d", i));
        end

        // Reset wins over EN and discards that cycle's operands.
        applyStimulus8(1'b0, 1'b1, 8'hFF, 8'hFF);
        pushExp(16'h0000, 16'h00FF, 1'b1);
        tick;
        compare8("r8.pre_rst");
        applyStimulus8(1'b1, 1'b1, 8'hFF, 8'hFF);
        pushExp(16'h0000, 16'h0000, 1'b0);
        tick;
        compare8("r8.mid_rst");
        applyStimulus8(1'b0, 1'b1, 8'hFF, 8'hFF);
        pushExp(16'h0000, 16'h00FF, 1'b1);
        tick;
        compare8("r8.post_rst");

        // Random pipeline against a model that remembers the last capture.
        held_s = '0;
        held_c = '0;
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            ren = 1'($urandom_range(0, 1));
            r16_a  = ra;
            r16_b  = rb;
            r16_en = ren;
            if (ren) begin
                held_s = ra ^ rb;
                held_c = ra & rb;
            end
            pushExp(held_s, held_c, ren);
            tick;
            compare16($sformatf("r16.cyc%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_half_adder
